// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer slice.
package pc_seq_pkg;

  // Sequencer mode: waiting for Start, fetching, or finished.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int PC_W_DEF        = 10;
  localparam int LUT_AW_DEF      = 5;
  localparam int STACK_DEPTH_DEF = 4;

  // Last instruction ROM address for the default PC width.
  localparam logic [PC_W_DEF-1:0] ROM_LAST = '1;

endpackage

// File: rtl/pc_sequencer_link_stack.sv
// link_stack: small LIFO of return addresses used by Call/Ret.
// Push while full and pop while empty are ignored here; the sequencer
// checks full/empty itself and raises its fault instead.
module link_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_idx  = IW'(count - CW'(1));
  assign wr_idx   = IW'(count);
  assign top_data = empty ? '0 : mem[top_idx];

  // Occupancy counter and storage; pop takes precedence over push.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      count       <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns ProgCtr and steps it through start, fetch, stall,
// branches and halt. Optional return-address stack is enabled with the
// FETCH_LINK_STACK_EN macro; without it Call/Ret act as plain increments.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int LUT_AW      = LUT_AW_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchAbs,
  input  logic              BranchRel,
  input  logic              Taken,
  input  logic              Call,
  input  logic              Ret,
  input  logic [LUT_AW-1:0] BranchPtr,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  localparam logic [PC_W-1:0] LAST_ADDR = '1;

  seq_state_t      state, state_next;
  logic [PC_W-1:0] pc_next;
  logic            fault_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;

  assign LutAddr = BranchPtr;
  assign pc_inc  = ProgCtr + PC_W'(1);
  assign pc_rel  = ProgCtr + Target;
  assign Busy    = (state == RUN);
  assign Done    = (state == DONE);

`ifdef FETCH_LINK_STACK_EN
  logic            stack_push, stack_pop, stack_clear;
  logic            stack_full, stack_empty;
  logic [PC_W-1:0] stack_top;

  link_stack #(
    .WIDTH(PC_W),
    .DEPTH(STACK_DEPTH)
  ) u_link_stack (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (stack_clear),
    .push     (stack_push),
    .pop      (stack_pop),
    .push_data(pc_inc),
    .top_data (stack_top),
    .full     (stack_full),
    .empty    (stack_empty)
  );
`else
  logic unused_link;
  assign unused_link = ^{Call, Ret, STACK_DEPTH[0]};
`endif

  // State, program counter and sticky fault registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      Fault   <= 1'b0;
    end else begin
      state   <= state_next;
      ProgCtr <= pc_next;
      Fault   <= fault_next;
    end
  end

  // Next-state and next-PC decision following the RUN priority order.
  always_comb begin
    state_next = state;
    pc_next    = ProgCtr;
    fault_next = Fault;
`ifdef FETCH_LINK_STACK_EN
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    stack_clear = 1'b0;
`endif
    case (state)
      RUN: begin
        if (Halt) begin
          state_next = DONE;
        end else if (Stall) begin
          state_next = RUN;
`ifdef FETCH_LINK_STACK_EN
        end else if (Ret) begin
          if (stack_empty) begin
            fault_next = 1'b1;
            state_next = DONE;
          end else begin
            stack_pop = 1'b1;
            pc_next   = stack_top;
          end
        end else if (Call) begin
          if (stack_full) begin
            fault_next = 1'b1;
            state_next = DONE;
          end else begin
            stack_push = 1'b1;
            pc_next    = Target;
          end
`endif
        end else if (BranchAbs && Taken) begin
          pc_next = Target;
        end else if (BranchRel && Taken) begin
          pc_next = pc_rel;
        end else if (ProgCtr == LAST_ADDR) begin
          pc_next    = '0;
          fault_next = 1'b1;
          state_next = DONE;
        end else begin
          pc_next = pc_inc;
        end
      end
      default: begin
        if (Start) begin
          pc_next    = StartAddr;
          fault_next = 1'b0;
          state_next = RUN;
`ifdef FETCH_LINK_STACK_EN
          stack_clear = 1'b1;
`endif
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
// Link-stack scenarios are included when FETCH_LINK_STACK_EN is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int PCW      = PC_W_DEF;
  localparam int AW       = LUT_AW_DEF;
  localparam int DEPTH    = STACK_DEPTH_DEF;
  localparam int ROM_SIZE = 1 << PCW;
`ifdef FETCH_LINK_STACK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, start, stall, halt, babs, brel, taken, call, ret;
  logic [PCW-1:0] start_addr, target;
  logic [AW-1:0]  ptr;
  logic [AW-1:0]  lut_addr;
  logic [PCW-1:0] prog_ctr;
  logic           busy, done, fault;

  int checks = 0;
  int errors = 0;

  int m_pc;
  bit m_busy, m_done, m_fault;
  int m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk      (clk),
    .Reset    (rst),
    .Start    (start),
    .StartAddr(start_addr),
    .Stall    (stall),
    .Halt     (halt),
    .BranchAbs(babs),
    .BranchRel(brel),
    .Taken    (taken),
    .Call     (call),
    .Ret      (ret),
    .BranchPtr(ptr),
    .LutAddr  (lut_addr),
    .Target   (target),
    .ProgCtr  (prog_ctr),
    .Busy     (busy),
    .Done     (done),
    .Fault    (fault)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    rst = 0; start = 0; stall = 0; halt = 0;
    babs = 0; brel = 0; taken = 0; call = 0; ret = 0;
    start_addr = '0;
    ptr = AW'($urandom);
  endtask

  function automatic int wrapPc(input int v);
    return ((v % ROM_SIZE) + ROM_SIZE) % ROM_SIZE;
  endfunction

  function automatic int signedOffset(input int t);
    return (t >= ROM_SIZE / 2) ? t - ROM_SIZE : t;
  endfunction

  task automatic finishWithFault();
    m_fault = 1; m_busy = 0; m_done = 1;
  endtask

  task automatic modelStep();
    if (rst) begin
      m_pc = 0; m_busy = 0; m_done = 0; m_fault = 0;
      m_stack.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_pc = int'(start_addr); m_fault = 0; m_busy = 1; m_done = 0;
        m_stack.delete();
      end
    end else if (halt) begin
      m_busy = 0; m_done = 1;
    end else if (stall) begin
      m_busy = 1;
    end else if (LINK && ret) begin
      if (m_stack.size() == 0) finishWithFault();
      else m_pc = m_stack.pop_back();
    end else if (LINK && call) begin
      if (m_stack.size() == DEPTH) finishWithFault();
      else begin
        m_stack.push_back(wrapPc(m_pc + 1));
        m_pc = int'(target);
      end
    end else if (babs && taken) begin
      m_pc = int'(target);
    end else if (brel && taken) begin
      m_pc = wrapPc(m_pc + signedOffset(int'(target)));
    end else if (m_pc == ROM_SIZE - 1) begin
      m_pc = 0;
      finishWithFault();
    end else begin
      m_pc = m_pc + 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_pc"}, 32'(prog_ctr), 32'(m_pc));
    checkVal({tag, "_busy"}, 32'(busy), 32'(m_busy));
    checkVal({tag, "_done"}, 32'(done), 32'(m_done));
    checkVal({tag, "_fault"}, 32'(fault), 32'(m_fault));
  endtask

  task automatic applyStimulus(input string tag);
    #1;
    checkVal({tag, "_lut"}, 32'(lut_addr), 32'(ptr));
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
    clearInputs();
  endtask

  task automatic startAt(input int addr);
    start = 1; start_addr = PCW'(addr);
    applyStimulus("start");
  endtask

  task automatic haltNow();
    halt = 1;
    applyStimulus("halt");
  endtask

  initial begin
    target = '0;
    m_pc = 0; m_busy = 0; m_done = 0; m_fault = 0;
    clearInputs();
    @(posedge clk);
    #1;

    rst = 1; applyStimulus("reset");
    rst = 1; applyStimulus("reset2");
    babs = 1; taken = 1; target = 10'd9; applyStimulus("idle_branch_ignored");

    stall = 1; start = 1; start_addr = 10'd5; applyStimulus("stall_start");
    for (int i = 0; i < 3; i++) applyStimulus("seq");
    start = 1; start_addr = 10'd77; applyStimulus("start_in_run_ignored");
    haltNow();

    startAt(20);
    babs = 1; taken = 1; target = 10'd100; applyStimulus("babs_taken");
    haltNow();
    startAt(20);
    babs = 1; taken = 0; target = 10'd100; applyStimulus("babs_untaken");
    haltNow();

    startAt(50);
    brel = 1; taken = 1; target = 10'h3FC; applyStimulus("brel_back");
    haltNow();
    startAt(2);
    brel = 1; taken = 1; target = 10'h3FC; applyStimulus("brel_wrap");
    babs = 1; brel = 1; taken = 1; target = 10'd7; applyStimulus("abs_over_rel");
    haltNow();

    startAt(30);
    for (int i = 0; i < 3; i++) begin
      stall = 1; applyStimulus("stall");
    end
    applyStimulus("after_stall");
    stall = 1; halt = 1; applyStimulus("halt_over_stall");
    babs = 1; taken = 1; target = 10'd300; applyStimulus("done_hold");

    startAt(10'h3FE);
    applyStimulus("inc_top");
    applyStimulus("inc_wrap");
    applyStimulus("done_after_wrap");
    startAt(10'h010);

    babs = 1; taken = 1; target = 10'd99; rst = 1; applyStimulus("reset_mid_run");

`ifdef FETCH_LINK_STACK_EN
    startAt(10);
    call = 1; target = 10'd200; applyStimulus("call");
    ret = 1; applyStimulus("ret");
    ret = 1; call = 1; target = 10'd5; applyStimulus("ret_empty");
    startAt(10);
    for (int i = 0; i < 5; i++) begin
      call = 1; target = PCW'(300 + i); applyStimulus("nested_call");
    end
    startAt(40);
    call = 1; target = 10'd500; applyStimulus("call_a");
    call = 1; target = 10'd600; applyStimulus("call_b");
    ret = 1; applyStimulus("ret_b");
    ret = 1; applyStimulus("ret_a");
`endif

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom % 64) == 0;
      start = ($urandom % 6) == 0;
      start_addr = (($urandom % 4) == 0) ? PCW'(ROM_SIZE - 4 + int'($urandom % 4))
                                         : PCW'($urandom);
      stall = ($urandom % 5) == 0;
      halt  = ($urandom % 25) == 0;
      babs  = ($urandom % 4) == 0;
      brel  = ($urandom % 4) == 0;
      taken = $urandom % 2;
      call  = ($urandom % 6) == 0;
      ret   = ($urandom % 6) == 0;
      target = PCW'($urandom);
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle core. It owns the 10-bit ProgCtr register and sequences it through start, sequential fetch, stall, absolute and relative branches, and halt. Branches carry only a 5-bit pointer, so the block drives that pointer to the branch-target lookup table and consumes its 10-bit Target in the same cycle. It sits between the instruction decoder/control unit and instruction ROM, and exposes the Start/Done handshake to the testbench.

## Interface
- PC_W, 10: program counter width; instruction ROM depth is 2**PC_W.
- LUT_AW, 5: branch-target pointer width.
- STACK_DEPTH, 4: link-stack entries; used only with FETCH_LINK_STACK_EN.

- Clk  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse; begins a program at StartAddr.
- StartAddr  in  PC_W  first instruction address.
- Stall  in  1  hold ProgCtr this cycle.
- Halt  in  1  decoder sees the halt instruction.
- BranchAbs  in  1  absolute-branch instruction.
- BranchRel  in  1  relative-branch instruction.
- Taken  in  1  branch condition true.
- Call  in  1  call instruction (link stack).
- Ret  in  1  return instruction (link stack).
- BranchPtr  in  LUT_AW  pointer field from the instruction.
- LutAddr  out  LUT_AW  to the LUT; combinationally equals BranchPtr.
- Target  in  PC_W  from the LUT.
- ProgCtr  out  PC_W  registered fetch address.
- Busy  out  1  high in RUN.
- Done  out  1  high in DONE.
- Fault  out  1  sticky error flag.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts it in IDLE with ProgCtr=0, Busy=0, Done=0, Fault=0, and the stack empty.
- IDLE/DONE + Start: ProgCtr<=StartAddr, Fault<=0, stack cleared, next state RUN. Start is ignored in RUN.
- RUN priority, highest first:
  - Halt: ProgCtr holds, go to DONE.
  - Stall: hold everything.
  - Ret (macro): pop the stack.
  - Call (macro): push ProgCtr+1, then ProgCtr<=Target.
  - BranchAbs&Taken: ProgCtr<=Target.
  - BranchRel&Taken: ProgCtr<=ProgCtr+Target. Target is treated as PC_W-bit two's complement and the sum is taken mod 2**PC_W.
  - Otherwise ProgCtr<=ProgCtr+1.
- Untaken branch: ProgCtr+1.
- BranchAbs and BranchRel both high: BranchAbs wins.
- Sequential increment from 2**PC_W-1: ProgCtr wraps to 0, Fault<=1, go to DONE. Branch arithmetic wraps silently.
- Branch inputs are ignored outside RUN. ProgCtr holds in IDLE/DONE.

## Timing
- Target is consumed combinationally in the same cycle as BranchPtr; LutAddr has zero latency.
- Every ProgCtr update is visible one cycle after the deciding edge.
- Start in cycle N gives ProgCtr=StartAddr and Busy=1 at N+1.
- Halt in cycle N gives Done=1 and Busy=0 at N+1. Done stays high until Start or Reset.
- Reset asserted mid-RUN returns to IDLE on that edge and discards the in-flight branch.
- Stall together with Halt: Halt wins. Stall together with Start in IDLE: Start wins.

## Configuration
- FETCH_LINK_STACK_EN defined:
  - A STACK_DEPTH-entry LIFO of return addresses is built.
  - Push when full, or pop when empty, sets Fault=1 and goes to DONE. ProgCtr holds on that error.
  - Call and Ret in the same cycle: Ret wins.
- FETCH_LINK_STACK_EN undefined:
  - No stack storage.
  - Call and Ret are ignored, so those instructions behave as plain increments.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - PC_W and LUT_AW defaults;
  - a localparam for the ROM last address.
- Natural sub-module: link_stack, a parameterized LIFO with push, pop, data, full and empty. It is instantiated only under FETCH_LINK_STACK_EN.

## Test plan
- Reset, then Start with StartAddr=10'd5, then 3 idle cycles: ProgCtr runs 5,6,7,8 with Busy=1; Done=0.
- In RUN at PC=20, BranchAbs&Taken with Target=10'd100: ProgCtr=100 next cycle. The same stimulus with Taken=0 gives 21.
- At PC=50, BranchRel&Taken with Target=10'h3FC (-4): 46. At PC=2 with the same Target: 10'h3FE, Fault stays 0.
- Stall held 3 cycles at PC=30: ProgCtr stays 30, then 31. Halt raised during Stall: Done=1 next cycle, and Start restarts with Fault=0.
- Start with StartAddr=10'h3FE, 2 increments: PC goes 3FE, 3FF, then 0 with Fault=1 and Done=1.
- With FETCH_LINK_STACK_EN: Call at PC=10 with Target=200, then Ret gives PC 200 then 11. 5 nested Calls with depth 4 give Fault=1 on the fifth.
